// File: rtl/traffic_light_controller_multi.sv
// traffic_light_controller_multi
//   N-approach traffic light controller. Road 0 is the main road and rests on
//   green. Side roads 1..NUM_ROADS-1 request service through their sensors and
//   are served round-robin. Each service runs GREEN -> YELLOW -> ALL_RED.
//   Lamps are decoded only from registered state.
//   Optional feature: define EMERGENCY_PREEMPT_EN to add the preempt and
//   preempt_road inputs, which force the green to a chosen road.
module traffic_light_controller_multi #(
    parameter int NUM_ROADS      = 3,
    parameter int CNT_W          = 16,
    parameter int MAIN_MIN_GREEN = 8,
    parameter int SIDE_MIN_GREEN = 4,
    parameter int SIDE_MAX_GREEN = 12,
    parameter int YELLOW_TIME    = 3,
    parameter int ALL_RED_TIME   = 2,
    localparam int ROAD_W        = (NUM_ROADS <= 2) ? 1 : $clog2(NUM_ROADS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_ROADS-1:0]   sensor,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                   preempt,
    input  logic [ROAD_W-1:0]      preempt_road,
`endif
    output logic [3*NUM_ROADS-1:0] lights,
    output logic [ROAD_W-1:0]      green_road,
    output logic [1:0]             phase
);

    localparam logic [1:0] PH_GREEN   = 2'd0;
    localparam logic [1:0] PH_YELLOW  = 2'd1;
    localparam logic [1:0] PH_ALL_RED = 2'd2;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    // Timer values seen on the last cycle of each timed interval.
    localparam logic [CNT_W-1:0] MAIN_MIN_LAST = CNT_W'(MAIN_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] SIDE_MIN_LAST = CNT_W'(SIDE_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] SIDE_MAX_LAST = CNT_W'(SIDE_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST   = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LAST  = CNT_W'(ALL_RED_TIME - 1);

    logic [1:0]        phase_q, phase_d;
    logic [ROAD_W-1:0] green_road_q, green_road_d;
    logic [ROAD_W-1:0] next_road_q, next_road_d;
    logic [ROAD_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  timer_q, timer_d;

    logic              side_req;
    logic [ROAD_W-1:0] rr_pick;
    logic [ROAD_W-1:0] rr_cand;
    logic [CNT_W-1:0]  timer_inc;
    logic              preempt_ok;

    assign side_req  = |sensor[NUM_ROADS-1:1];
    assign timer_inc = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + 1'b1;

`ifdef EMERGENCY_PREEMPT_EN
    // An out-of-range preempt target is treated as no preempt at all.
    assign preempt_ok = preempt && (int'(preempt_road) < NUM_ROADS);
`else
    assign preempt_ok = 1'b0;
`endif

    // Round-robin pick: nearest requesting side road after rr_ptr, wrapping
    // from NUM_ROADS-1 back to road 1. Scanning farthest-first lets the
    // nearest candidate overwrite the others.
    always_comb begin
        rr_pick = '0;
        rr_cand = '0;
        for (int i = NUM_ROADS - 1; i >= 1; i--) begin
            rr_cand = ROAD_W'((int'(rr_ptr_q) + i - 1) % (NUM_ROADS - 1) + 1);
            if (sensor[rr_cand]) begin
                rr_pick = rr_cand;
            end
        end
    end

    // Phase sequencing, timer and road selection.
    always_comb begin
        phase_d      = phase_q;
        green_road_d = green_road_q;
        next_road_d  = next_road_q;
        rr_ptr_d     = rr_ptr_q;
        timer_d      = timer_inc;
        case (phase_q)
            PH_GREEN: begin
                if (green_road_q == '0) begin
                    if (timer_q >= MAIN_MIN_LAST && side_req) begin
                        phase_d     = PH_YELLOW;
                        timer_d     = '0;
                        next_road_d = rr_pick;
                        rr_ptr_d    = rr_pick;
                    end
                end else begin
                    if ((timer_q >= SIDE_MIN_LAST && !sensor[green_road_q]) ||
                        timer_q == SIDE_MAX_LAST) begin
                        phase_d     = PH_YELLOW;
                        timer_d     = '0;
                        next_road_d = '0;
                    end
                end
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt_ok) begin
                    if (green_road_q != preempt_road) begin
                        // Leave immediately, waiving min-green.
                        phase_d     = PH_YELLOW;
                        timer_d     = '0;
                        next_road_d = preempt_road;
                        rr_ptr_d    = rr_ptr_q;
                    end else begin
                        // Hold the preempted road with no timeout.
                        phase_d     = PH_GREEN;
                        timer_d     = timer_inc;
                        next_road_d = next_road_q;
                        rr_ptr_d    = rr_ptr_q;
                    end
                end
`endif
            end
            PH_YELLOW: begin
                if (preempt_ok) begin
`ifdef EMERGENCY_PREEMPT_EN
                    next_road_d = preempt_road;
`endif
                end
                if (timer_q == YELLOW_LAST) begin
                    phase_d = PH_ALL_RED;
                    timer_d = '0;
                end
            end
            PH_ALL_RED: begin
                if (preempt_ok) begin
`ifdef EMERGENCY_PREEMPT_EN
                    next_road_d = preempt_road;
`endif
                end
                if (timer_q == ALL_RED_LAST) begin
                    phase_d      = PH_GREEN;
                    timer_d      = '0;
                    green_road_d = next_road_d;
                end
            end
            default: begin
                phase_d      = PH_GREEN;
                green_road_d = '0;
                timer_d      = '0;
            end
        endcase
    end

    // State registers, returning to main-road green on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q      <= PH_GREEN;
            green_road_q <= '0;
            next_road_q  <= '0;
            rr_ptr_q     <= '0;
            timer_q      <= '0;
        end else begin
            phase_q      <= phase_d;
            green_road_q <= green_road_d;
            next_road_q  <= next_road_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
        end
    end

    // Lamp decode: only green_road may be lit non-red, and never in ALL_RED.
    for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_lamp
        assign lights[3*gi +: 3] =
            (green_road_q != ROAD_W'(gi)) ? LAMP_RED    :
            (phase_q == PH_GREEN)         ? LAMP_GREEN  :
            (phase_q == PH_YELLOW)        ? LAMP_YELLOW : LAMP_RED;
    end

    assign green_road = green_road_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_controller_multi.sv
// Directed bench for traffic_light_controller_multi (default parameters).
// Expected per-cycle {green_road, phase, lights} entries are queued as each
// scenario is set up and popped one per clock as the DUT runs.
module tb_traffic_light_controller_multi;

    localparam int N = 3;

    logic       clk    = 1'b0;
    logic       rstn   = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic [8:0] lights;
    logic [1:0] green_road;
    logic [1:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt      = 1'b0;
    logic [1:0] preempt_road = 2'd0;
`endif

    always #5 clk = ~clk;

    traffic_light_controller_multi dut (
        .clk          (clk),
        .rstn         (rstn),
        .sensor       (sensor),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt      (preempt),
        .preempt_road (preempt_road),
`endif
        .lights       (lights),
        .green_road   (green_road),
        .phase        (phase)
    );

    typedef struct packed {
        logic [1:0] gr;
        logic [1:0] ph;
        logic [8:0] lt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [1:0] G  = 2'd0;
    localparam logic [1:0] Y  = 2'd1;
    localparam logic [1:0] AR = 2'd2;

    function automatic logic [8:0] exp_lights(input logic [1:0] road, input logic [1:0] ph);
        logic [8:0] v;
        v = '0;
        for (int r = 0; r < N; r++) begin
            if (r == int'(road) && ph == G)      v[3*r +: 3] = 3'b001;
            else if (r == int'(road) && ph == Y) v[3*r +: 3] = 3'b010;
            else                                 v[3*r +: 3] = 3'b100;
        end
        return v;
    endfunction

    function automatic int nonred(input logic [8:0] lt);
        int c;
        c = 0;
        for (int r = 0; r < N; r++) if (lt[3*r +: 3] !== 3'b100) c++;
        return c;
    endfunction

    task automatic push_seg(input logic [1:0] road, input logic [1:0] ph, input int n);
        exp_t e;
        e.gr = road;
        e.ph = ph;
        e.lt = exp_lights(road, ph);
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic check_cycle(input string tag);
        exp_t o;
        exp_t e;
        o = {green_road, phase, lights};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s scoreboard empty, observed gr=%0d ph=%0d lights=%b", tag, o.gr, o.ph, o.lt);
        end else begin
            e = sb.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s observed gr=%0d ph=%0d lights=%b expected gr=%0d ph=%0d lights=%b",
                       tag, o.gr, o.ph, o.lt, e.gr, e.ph, e.lt);
            end
        end
        vectors++;
        assert (nonred(lights) <= 1) else begin
            miscompares++;
            $error("FAIL %s non-red roads observed=%0d expected<=1", tag, nonred(lights));
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle(tag);
            @(negedge clk);
        end
        $display("%s: %0d cycles checked", tag, n);
    endtask

    // Assert reset at a falling edge and check the reset state asynchronously.
    task automatic apply_reset(input string tag);
        rstn = 1'b0;
        #1;
        push_seg(2'd0, G, 1);
        check_cycle(tag);
        @(negedge clk);
    endtask

    initial begin
        // 1: reset state, then idle main green with no requests
        #1;
        vectors++;
        assert (lights === 9'b100_100_001) else begin
            miscompares++;
            $error("FAIL t1_reset_lights observed=%b expected=%b", lights, 9'b100_100_001);
        end
        push_seg(2'd0, G, 1);
        check_cycle("t1_reset");
        @(negedge clk);
        rstn = 1'b1;
        push_seg(2'd0, G, 100);
        run("t1_idle", 100);

        // 2: sensor[1] held from release
        apply_reset("t2_reset");
        sensor = 3'b010;
        rstn   = 1'b1;
        push_seg(2'd0, G, 8);  push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd1, G, 12); push_seg(2'd1, Y, 3); push_seg(2'd1, AR, 2);
        push_seg(2'd0, G, 8);  push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd1, G, 2);
        run("t2_side1_held", 45);

        // 3: sensor[1] dropped on road1's second green cycle
        apply_reset("t3_reset");
        sensor = 3'b010;
        rstn   = 1'b1;
        push_seg(2'd0, G, 8); push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd1, G, 1);
        run("t3_to_side1", 14);
        sensor = 3'b000;
        push_seg(2'd1, G, 3); push_seg(2'd1, Y, 3); push_seg(2'd1, AR, 2);
        push_seg(2'd0, G, 20);
        run("t3_min_green", 28);

        // 4: both side roads requesting, round-robin order 0,1,0,2,0,1
        apply_reset("t4_reset");
        sensor = 3'b110;
        rstn   = 1'b1;
        push_seg(2'd0, G, 8);  push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd1, G, 12); push_seg(2'd1, Y, 3); push_seg(2'd1, AR, 2);
        push_seg(2'd0, G, 8);  push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd2, G, 12); push_seg(2'd2, Y, 3); push_seg(2'd2, AR, 2);
        push_seg(2'd0, G, 8);  push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd1, G, 3);
        run("t4_round_robin", 76);

        // 5: reset pulsed in the middle of road1 yellow
        apply_reset("t5_reset");
        sensor = 3'b010;
        rstn   = 1'b1;
        push_seg(2'd0, G, 8);  push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd1, G, 12); push_seg(2'd1, Y, 1);
        run("t5_to_yellow", 26);
        #2;
        rstn = 1'b0;
        #1;
        push_seg(2'd0, G, 1);
        check_cycle("t5_async_reset");
        @(negedge clk);
        rstn = 1'b1;
        push_seg(2'd0, G, 8); push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd1, G, 2);
        run("t5_after_reset", 15);

`ifdef EMERGENCY_PREEMPT_EN
        // 6: preempt to road 2 from main-green cycle 1, held past side max
        apply_reset("t6_reset");
        sensor       = 3'b000;
        preempt      = 1'b1;
        preempt_road = 2'd2;
        rstn         = 1'b1;
        push_seg(2'd0, G, 1); push_seg(2'd0, Y, 3); push_seg(2'd0, AR, 2);
        push_seg(2'd2, G, 20);
        run("t6_preempt_hold", 26);
        preempt = 1'b0;
        push_seg(2'd2, G, 1); push_seg(2'd2, Y, 3); push_seg(2'd2, AR, 2);
        push_seg(2'd0, G, 5);
        run("t6_release", 11);
`endif

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drained observed=%0d leftover expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
